// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default frame geometry and the parity
// helper used by both the transmitter and receiver checking.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam logic LINE_IDLE    = 1'b1;

    // XOR of all data bits; inverted for odd parity.
    // Narrower bytes are zero-extended, which leaves the XOR unchanged.
    function automatic logic parityOf(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter: strobes bitEnd on the last clock of each serial
// bit and restarts at zero whenever a frame starts or the line goes idle.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic baudRateOut,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bitEnd
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick;

    assign bitEnd = run && (tick == LAST);

    // Count 0..OVERSAMPLE-1 while a frame runs, wrapping at each bit end.
    always_ff @(posedge baudRateOut or negedge rst) begin
        if (!rst) begin
            tick <= '0;
        end else if (clear || !run || bitEnd) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter_fsm.sv
// UART transmitter: valid/ready byte intake, start/data/parity/stop framing,
// registered line output and a one-clock done pulse per frame.
module uart_transmitter_fsm
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 baudRateOut,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 serialOutput,
    output logic                 txBusy,
    output logic                 txDone
);

    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    txState_t state;
    txState_t nextState;

    logic [DATA_BITS-1:0] shreg;
    logic [IW-1:0]        bitIdx;
    logic                 parityReg;
    logic                 accept;
    logic                 bitEnd;
    logic                 lastBit;
    logic                 lineNext;
    logic                 doneNext;

    assign accept   = txValid && txReady;
    assign doneNext = (state == STOP) && bitEnd && lastBit;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) bitTimer (
        .baudRateOut(baudRateOut),
        .rst        (rst),
        .clear      (accept),
        .run        (state != IDLE),
        .bitEnd     (bitEnd)
    );

    // State register.
    always_ff @(posedge baudRateOut or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, handshake and the line level for the coming clock.
    always_comb begin
        nextState = state;
        txReady   = 1'b0;
        txBusy    = 1'b1;
        lineNext  = LINE_IDLE;
        lastBit   = 1'b0;
        unique case (state)
            IDLE: begin
                txReady = 1'b1;
                txBusy  = 1'b0;
                if (txValid) nextState = START;
            end
            START: begin
                lineNext = 1'b0;
                if (bitEnd) nextState = DATA;
            end
            DATA: begin
                lineNext = shreg[0];
                lastBit  = (bitIdx == LAST_DATA);
                if (bitEnd && lastBit) nextState = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
                lineNext = parityReg;
                if (bitEnd) nextState = STOP;
            end
            STOP: begin
                lastBit = (bitIdx == LAST_STOP);
                if (bitEnd && lastBit) begin
                    txReady   = 1'b1;
                    nextState = txValid ? START : IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Byte latch, shifter, bit/stop index and registered line outputs.
    always_ff @(posedge baudRateOut or negedge rst) begin
        if (!rst) begin
            shreg        <= '0;
            parityReg    <= 1'b0;
            bitIdx       <= '0;
            serialOutput <= LINE_IDLE;
            txDone       <= 1'b0;
        end else begin
            serialOutput <= lineNext;
            txDone       <= doneNext;
            if (accept) begin
                shreg     <= dataIn;
                parityReg <= parityOf(32'(dataIn), PARITY_ODD);
                bitIdx    <= '0;
            end else if (bitEnd && (state == DATA)) begin
                shreg  <= shreg >> 1;
                bitIdx <= lastBit ? '0 : bitIdx + IW'(1);
            end else if (bitEnd && (state == STOP)) begin
                bitIdx <= lastBit ? '0 : bitIdx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter_fsm.sv
// Bench for uart_transmitter_fsm: an odd-parity and an even-parity instance,
// a line decoder per instance feeding a scoreboard of expected frames.
module tb_uart_transmitter_fsm;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0] dataIn  = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady, serialOutput, txBusy, txDone;

    logic [7:0] dataInE  = 8'h00;
    logic       txValidE = 1'b0;
    logic       txReadyE, serialOutputE, txBusyE, txDoneE;

    int cyc = 0;
    int nCompared = 0;
    int nMismatched = 0;
    int doneCnt = 0;
    int doneCntE = 0;
    int frames0 = 0;
    int frames1 = 0;

    expT q0[$];
    expT q1[$];
    int  doneLog[$];
    int  startLog[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_transmitter_fsm dut (
        .baudRateOut (clk),
        .rst         (rst),
        .dataIn      (dataIn),
        .txValid     (txValid),
        .txReady     (txReady),
        .serialOutput(serialOutput),
        .txBusy      (txBusy),
        .txDone      (txDone)
    );

    uart_transmitter_fsm #(
        .PARITY_ODD(1'b0)
    ) dutEven (
        .baudRateOut (clk),
        .rst         (rst),
        .dataIn      (dataInE),
        .txValid     (txValidE),
        .txReady     (txReadyE),
        .serialOutput(serialOutputE),
        .txBusy      (txBusyE),
        .txDone      (txDoneE)
    );

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic refParity(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic logic lineOf(input int w);
        return (w == 0) ? serialOutput : serialOutputE;
    endfunction

    always @(negedge clk) begin
        if (txDone) begin
            doneCnt++;
            doneLog.push_back(cyc);
        end
        if (txDoneE) doneCntE++;
    end

    task automatic pushExp(input int w, input logic [7:0] d);
        expT e;
        e.d = d;
        e.p = refParity(d, (w == 0));
        if (w == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic sendByte(input int w, input logic [7:0] d, output int acc);
        @(negedge clk);
        if (w == 0) begin
            dataIn  = d;
            txValid = 1'b1;
        end else begin
            dataInE  = d;
            txValidE = 1'b1;
        end
        pushExp(w, d);
        @(negedge clk);
        txValid  = 1'b0;
        txValidE = 1'b0;
        acc = cyc;
    endtask

    task automatic monLoop(input int w);
        logic [10:0] bits;
        logic stable, ok, v;
        int startC;
        expT e;
        forever begin
            @(negedge clk);
            if (rst && lineOf(w) == 1'b0) begin
                startC = cyc;
                stable = 1'b1;
                ok     = 1'b1;
                bits   = '0;
                for (int b = 0; b < 11; b++) begin
                    for (int t = 0; t < 16; t++) begin
                        if (b != 0 || t != 0) @(negedge clk);
                        if (!rst) ok = 1'b0;
                        v = lineOf(w);
                        if (t == 0) bits[b] = v;
                        else if (v != bits[b]) stable = 1'b0;
                    end
                    if (!ok) break;
                end
                if (!ok) begin
                    if (w == 0 && q0.size() > 0) e = q0.pop_front();
                    if (w == 1 && q1.size() > 0) e = q1.pop_front();
                end else begin
                    if (w == 0) begin
                        frames0++;
                        startLog.push_back(startC);
                    end else begin
                        frames1++;
                    end
                    if ((w == 0 ? q0.size() : q1.size()) == 0) begin
                        checkVal($sformatf("extraFrame%0d", w), 32'(bits[8:1]), 32'h1ff);
                    end else begin
                        e = (w == 0) ? q0.pop_front() : q1.pop_front();
                        checkVal($sformatf("data%0d", w), 32'(bits[8:1]), 32'(e.d));
                        checkVal($sformatf("parity%0d", w), 32'(bits[9]), 32'(e.p));
                        checkVal($sformatf("stop%0d", w), 32'(bits[10]), 32'h1);
                        checkVal($sformatf("bitStable%0d", w), 32'(stable), 32'h1);
                    end
                end
            end
        end
    endtask

    initial monLoop(0);
    initial monLoop(1);

    initial begin
        int acc, acc2, d0, f0;
        logic idleHigh;

        repeat (3) @(negedge clk);
        checkVal("rstLine", 32'(serialOutput), 32'h1);
        checkVal("rstReady", 32'(txReady), 32'h1);
        checkVal("rstBusy", 32'(txBusy), 32'h0);
        checkVal("rstDone", 32'(txDone), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        sendByte(0, 8'h55, acc);
        checkVal("busyAfterAccept", 32'(txBusy), 32'h1);
        checkVal("readyInFrame", 32'(txReady), 32'h0);
        repeat (200) @(negedge clk);
        checkVal("done55Count", 32'(doneCnt), 32'd1);
        if (doneLog.size() > 0)
            checkVal("done55Latency", 32'(doneLog[doneLog.size()-1] - acc), 32'd176);
        if (startLog.size() > 0)
            checkVal("start55Latency", 32'(startLog[startLog.size()-1] - acc), 32'd1);
        checkVal("idleAfter55", 32'(serialOutput), 32'h1);

        sendByte(1, 8'h00, acc);
        repeat (200) @(negedge clk);
        checkVal("evenIdleLine", 32'(serialOutputE), 32'h1);
        checkVal("evenIdleBusy", 32'(txBusyE), 32'h0);
        sendByte(1, 8'hFF, acc);
        repeat (200) @(negedge clk);
        checkVal("evenDoneCount", 32'(doneCntE), 32'd2);

        d0 = doneCnt;
        f0 = startLog.size();
        @(negedge clk);
        dataIn  = 8'hA5;
        txValid = 1'b1;
        pushExp(0, 8'hA5);
        @(negedge clk);
        acc = cyc;
        dataIn = 8'h3C;
        pushExp(0, 8'h3C);
        repeat (176) @(negedge clk);
        txValid = 1'b0;
        acc2 = cyc;
        repeat (200) @(negedge clk);
        checkVal("b2bDoneCount", 32'(doneCnt - d0), 32'd2);
        checkVal("b2bFrames", 32'(startLog.size() - f0), 32'd2);
        if (doneLog.size() >= 2) begin
            checkVal("b2bDoneGap",
                     32'(doneLog[doneLog.size()-1] - doneLog[doneLog.size()-2]), 32'd176);
            checkVal("b2bFirstDone", 32'(doneLog[doneLog.size()-2] - acc), 32'd176);
        end
        if (startLog.size() >= 2)
            checkVal("b2bStartGap",
                     32'(startLog[startLog.size()-1] - startLog[startLog.size()-2]),
                     32'(acc2 - acc));

        d0 = doneCnt;
        f0 = frames0;
        sendByte(0, 8'hF0, acc);
        repeat (39) @(negedge clk);
        dataIn  = 8'h0F;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        repeat (200) @(negedge clk);
        checkVal("ignoreDoneCount", 32'(doneCnt - d0), 32'd1);
        checkVal("ignoreFrames", 32'(frames0 - f0), 32'd1);

        d0 = doneCnt;
        sendByte(0, 8'h55, acc);
        repeat (69) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkVal("midRstLine", 32'(serialOutput), 32'h1);
        checkVal("midRstBusy", 32'(txBusy), 32'h0);
        checkVal("midRstReady", 32'(txReady), 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idleHigh = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (serialOutput !== 1'b1) idleHigh = 1'b0;
        end
        checkVal("postRstIdle", 32'(idleHigh), 32'h1);
        checkVal("midRstNoDone", 32'(doneCnt - d0), 32'd0);

        sendByte(0, 8'h55, acc);
        repeat (200) @(negedge clk);
        checkVal("postRstDone", 32'(doneCnt - d0), 32'd1);
        if (doneLog.size() > 0)
            checkVal("postRstLatency", 32'(doneLog[doneLog.size()-1] - acc), 32'd176);

        repeat (20) @(negedge clk);
        checkVal("q0Drained", 32'(q0.size()), 32'd0);
        checkVal("q1Drained", 32'(q1.size()), 32'd0);
        checkVal("framesMain", 32'(frames0), 32'd5);
        checkVal("framesEven", 32'(frames1), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
